// File: rtl/mips_pkg.sv
// Definitions shared by the fetch unit and the controller: FSM state encoding,
// the default reset PC, opcode/func constants and a word-alignment helper.
package mips_pkg;

  typedef logic [0:0] state_t;
  localparam state_t ST_FETCH = 1'b0;
  localparam state_t ST_EXEC  = 1'b1;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FUNC_JR   = 6'h08;
  localparam logic [5:0] FUNC_JALR = 6'h09;
  localparam logic [5:0] FUNC_ADD  = 6'h20;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory read port: the fetch unit is the master, memory the slave.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/ifetch_unit_npc.sv
// Next-PC selection: jr/jalr > j/jal > taken branch > sequential.
// The returned PC is word-aligned; misalign flags a target with low bits set.
module npc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [25:0] instr_index,
  input  logic [15:0] imm16,
  input  logic [31:0] rs_data,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic        zero,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic signed [31:0] br_off;
  logic        [31:0] target;

  assign br_off = signed'({{14{imm16[15]}}, imm16, 2'b00});

  always_comb begin
    target = pc_plus4;
    if (JumpReg) begin
      target = rs_data;
    end else if (Jump) begin
      target = {pc_plus4[31:28], instr_index, 2'b00};
    end else if (Branch && zero) begin
      target = pc_plus4 + unsigned'(br_off);
    end
  end

  assign next_pc  = word_align(target);
  assign misalign = |target[1:0];

endmodule

// File: rtl/ifetch_unit.sv
// Two-state multi-cycle fetch unit: FETCH waits for the memory ack and loads IR,
// EXEC exposes the decoded instruction and advances the PC when PCWre is given.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  ifetch_unit_if.master imem,
  output logic         instr_valid,
  output logic [5:0]   op,
  output logic [5:0]   func,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd,
  output logic [4:0]   shamt,
  output logic [15:0]  imm16,
  output logic [31:0]  pc_out,
  output logic [31:0]  pc_plus4,
  input  logic         PCWre,
  input  logic         Branch,
  input  logic         Jump,
  input  logic         JumpReg,
  input  logic         zero,
  input  logic [31:0]  rs_data,
  output logic [31:0]  retire_cnt,
  output logic         pc_misalign
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] next_pc;
  logic        npc_misalign;

  npc u_npc (
    .pc_plus4    (pc_plus4),
    .instr_index (ir[25:0]),
    .imm16       (ir[15:0]),
    .rs_data     (rs_data),
    .Branch      (Branch),
    .Jump        (Jump),
    .JumpReg     (JumpReg),
    .zero        (zero),
    .next_pc     (next_pc),
    .misalign    (npc_misalign)
  );

  // The ack is only honoured in FETCH, so a stale ack after reset simply
  // becomes the RESET_PC fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      retire_cnt  <= '0;
      pc_misalign <= 1'b0;
    end else begin
      pc_misalign <= 1'b0;
      if (state == ST_FETCH) begin
        if (imem.imem_ack) begin
          ir    <= imem.imem_rdata;
          state <= ST_EXEC;
        end
      end else if (PCWre) begin
        pc          <= next_pc;
        retire_cnt  <= retire_cnt + 32'd1;
        pc_misalign <= npc_misalign;
        state       <= ST_FETCH;
      end
    end
  end

  assign imem.imem_req  = (state == ST_FETCH);
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == ST_EXEC);

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign func     = ir[5:0];
  assign imm16    = ir[15:0];
  assign pc_out   = pc;
  assign pc_plus4 = pc + 32'd4;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios with literal expectations, then
// randomized traffic compared each cycle against an instruction-level model.
module tb_ifetch_unit;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [31:0] pc_out, pc_plus4, retire_cnt;
  logic        pc_misalign;
  logic        PCWre = 1'b0, Branch = 1'b0, Jump = 1'b0, JumpReg = 1'b0, zero = 1'b0;
  logic [31:0] rs_data = '0;

  int checks = 0;
  int errors = 0;

  ifetch_unit_if imem();

  ifetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem),
    .instr_valid (instr_valid),
    .op          (op),
    .func        (func),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .imm16       (imm16),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .PCWre       (PCWre),
    .Branch      (Branch),
    .Jump        (Jump),
    .JumpReg     (JumpReg),
    .zero        (zero),
    .rs_data     (rs_data),
    .retire_cnt  (retire_cnt),
    .pc_misalign (pc_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: m_busy means an instruction is held and executing.
  logic [31:0] m_pc, m_ir, m_cnt;
  logic        m_busy, m_mis;

  function automatic logic [31:0] model_target();
    logic [31:0] seq;
    int          off;
    seq = m_pc + 32'd4;
    off = int'($signed(m_ir[15:0])) * 4;
    if (JumpReg)            return rs_data;
    if (Jump)               return (seq & 32'hF000_0000) | (32'(m_ir[25:0]) * 32'd4);
    if (Branch && zero)     return seq + 32'(off);
    return seq;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [31:0] tgt;
    if (rst) begin
      m_pc = RST_PC; m_ir = '0; m_cnt = '0; m_busy = 1'b0; m_mis = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (!m_busy) begin
        if (imem.imem_ack) begin
          m_ir   = imem.imem_rdata;
          m_busy = 1'b1;
        end
      end else if (PCWre) begin
        tgt    = model_target();
        m_mis  = (tgt % 4) != 0;
        m_pc   = tgt - (tgt % 4);
        m_cnt  = m_cnt + 32'd1;
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("imem_req",    32'(imem.imem_req), 32'(!m_busy));
      chk("imem_addr",   imem.imem_addr, m_pc);
      chk("instr_valid", 32'(instr_valid), 32'(m_busy));
      chk("op",          32'(op),    32'(m_ir >> 26));
      chk("rs",          32'(rs),    (m_ir >> 21) & 32'h1F);
      chk("rt",          32'(rt),    (m_ir >> 16) & 32'h1F);
      chk("rd",          32'(rd),    (m_ir >> 11) & 32'h1F);
      chk("shamt",       32'(shamt), (m_ir >> 6) & 32'h1F);
      chk("func",        32'(func),  m_ir & 32'h3F);
      chk("imm16",       32'(imm16), m_ir & 32'hFFFF);
      chk("pc_out",      pc_out, m_pc);
      chk("pc_plus4",    pc_plus4, m_pc + 32'd4);
      chk("retire_cnt",  retire_cnt, m_cnt);
      chk("pc_misalign", 32'(pc_misalign), 32'(m_mis));
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    PCWre = 1'b0; Branch = 1'b0; Jump = 1'b0; JumpReg = 1'b0; zero = 1'b0;
  endtask

  // From FETCH: fetch word w (same-cycle ack), then execute with given controls.
  task automatic run_instr(input logic [31:0] w, input logic br, input logic jp,
                           input logic jr, input logic z, input logic [31:0] rsd);
    imem.imem_ack = 1'b1; imem.imem_rdata = w;
    wait_cycle();
    imem.imem_ack = 1'b0;
    PCWre = 1'b1; Branch = br; Jump = jp; JumpReg = jr; zero = z; rs_data = rsd;
    wait_cycle();
    clear_ctl();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] hold_addr;
    imem.imem_ack = 1'b0; imem.imem_rdata = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_req",   32'(imem.imem_req), 32'd1);
    chk("rst_addr",  imem.imem_addr, 32'h0000_3000);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_cnt",   retire_cnt, 32'd0);
    chk("rst_mis",   32'(pc_misalign), 32'd0);
    @(negedge clk); #1 rst = 1'b0;

    // addi $8,$0,5 with same-cycle ack
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h2008_0005;
    wait_cycle();
    imem.imem_ack = 1'b0;
    chk("addi_op",    32'(op), 32'h08);
    chk("addi_rt",    32'(rt), 32'd8);
    chk("addi_imm",   32'(imm16), 32'd5);
    chk("addi_valid", 32'(instr_valid), 32'd1);
    PCWre = 1'b1;
    wait_cycle();
    clear_ctl();
    chk("addi_pc",  pc_out, 32'h0000_3004);
    chk("addi_cnt", retire_cnt, 32'd1);

    // beq back to itself, then not taken
    rst = 1'b1; #1 rst = 1'b0;
    run_instr(32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("beq_taken", pc_out, 32'h0000_3000);
    run_instr(32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("beq_not_taken", pc_out, 32'h0000_3004);

    // nop to 0x3008, then j, then j with Branch also taken
    run_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("nop_pc", pc_out, 32'h0000_3008);
    run_instr(32'h0800_0C10, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("j_pc", pc_out, 32'h0000_3040);
    run_instr(32'h0800_0C10, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
    chk("j_over_branch", pc_out, 32'h0000_3040);

    // jr to a misaligned target
    run_instr(32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3011);
    chk("jr_pc",   pc_out, 32'h0000_3010);
    chk("jr_mis1", 32'(pc_misalign), 32'd1);
    wait_cycle();
    chk("jr_mis2", 32'(pc_misalign), 32'd0);

    // fetch wait without ack
    hold_addr = imem.imem_addr;
    for (int i = 0; i < 5; i++) begin
      wait_cycle();
      chk("wait_req",  32'(imem.imem_req), 32'd1);
      chk("wait_addr", imem.imem_addr, hold_addr);
    end
    chk("wait_addr_lit", imem.imem_addr, 32'h0000_3010);

    // EXEC stall with PCWre=0
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h0000_0000;
    wait_cycle();
    imem.imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_cycle();
      chk("stall_pc",    pc_out, 32'h0000_3010);
      chk("stall_cnt",   retire_cnt, 32'd6);
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    PCWre = 1'b1;
    wait_cycle();
    clear_ctl();
    chk("stall_release_pc",  pc_out, 32'h0000_3014);
    chk("stall_release_cnt", retire_cnt, 32'd7);

    // wrap-around at the top of the address space
    run_instr(32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC);
    chk("wrap_pc",   pc_out, 32'hFFFF_FFFC);
    chk("wrap_pc4",  pc_plus4, 32'h0000_0000);
    run_instr(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc0",  pc_out, 32'h0000_0000);

    // async reset while waiting in FETCH, ack right after release
    wait_cycle();
    rst = 1'b1;
    #1;
    chk("arst_req",   32'(imem.imem_req), 32'd1);
    chk("arst_addr",  imem.imem_addr, 32'h0000_3000);
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_cnt",   retire_cnt, 32'd0);
    wait_cycle();
    rst = 1'b0;
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h2008_0005;
    wait_cycle();
    imem.imem_ack = 1'b0;
    chk("arst_fetch_valid", 32'(instr_valid), 32'd1);
    chk("arst_fetch_pc",    pc_out, 32'h0000_3000);
    chk("arst_fetch_op",    32'(op), 32'h08);

    // randomized traffic, checked each cycle by the model
    for (int i = 0; i < 600; i++) begin
      imem.imem_ack   = ($urandom_range(0, 2) != 0);
      imem.imem_rdata = $urandom;
      PCWre   = ($urandom_range(0, 3) != 0);
      Branch  = $urandom_range(0, 1) == 1;
      zero    = $urandom_range(0, 1) == 1;
      Jump    = $urandom_range(0, 3) == 0;
      JumpReg = $urandom_range(0, 5) == 0;
      rs_data = $urandom;
      wait_cycle();
    end
    clear_ctl();
    imem.imem_ack = 1'b0;
    wait_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
